uart_tx_sequencer: RTL and testbench

//  Next-generation UART transmit sequencer between message ROM/regfile, UART RX and UART TX.
//  A toggle on printf sends an MSG_LEN-byte message, fetched byte-by-byte through o_msg_idx.

---
 rtl/uart_seq_pkg.sv | 21 ++
 rtl/uart_echo_fifo.sv | 48 ++++
 rtl/uart_tx_sequencer.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_seq_pkg.sv
// rtl/uart_seq_pkg.sv - shared state encoding and trailer characters for the UART TX sequencer
// Optional CR/LF trailer is enabled by defining UART_SEQ_CRLF_EN.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MSG_LOAD  = 3'd1,
    ST_MSG_SEND  = 3'd2,
    ST_ECHO_SEND = 3'd3
`ifdef UART_SEQ_CRLF_EN
    ,
    ST_CRLF      = 3'd4
`endif
  } seq_state_t;

`ifdef UART_SEQ_CRLF_EN
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
`endif

endpackage

// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - synchronous echo FIFO with combinational head output
module uart_echo_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_en;
  logic              rd_en;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still taken.
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update, wrapping naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - sends ROM messages on printf toggles and echoes received bytes
// Define UART_SEQ_CRLF_EN to append 0x0D,0x0A after every message.
module uart_tx_sequencer
  import uart_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MSG_LEN    = 16,
  parameter int IDX_W      = 8,
  parameter int ECHO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              printf,
  input  logic [DATA_W-1:0] msg_char,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [IDX_W-1:0]  o_msg_idx,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  output logic              o_busy,
  output logic              o_echo_overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  seq_state_t        state, state_d;
  logic              printf_q;
  logic              pend;
  logic              pend_clr;
  logic              toggle;
  logic              xfer;
  logic [IDX_W-1:0]  idx_d;
  logic [DATA_W-1:0] tx_data_d;
  logic              tx_valid_d;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_head;
`ifdef UART_SEQ_CRLF_EN
  logic              crlf_lf, crlf_lf_d;
`endif

  assign toggle = printf ^ printf_q;
  assign xfer   = o_tx_valid & tx_ready;
  assign o_busy = (state != ST_IDLE);

  uart_echo_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (ECHO_DEPTH)
  ) u_echo_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .pop   (fifo_pop),
    .din   (rx_data),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Print request capture: any toggles before service collapse into a single pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      printf_q <= 1'b0;
      pend     <= 1'b0;
    end else begin
      printf_q <= printf;
      if (toggle)        pend <= 1'b1;
      else if (pend_clr) pend <= 1'b0;
    end
  end

  // Sticky flag for an RX byte lost to a full FIFO with no simultaneous pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    o_echo_overflow <= 1'b0;
    else if (rx_valid && fifo_full && !fifo_pop) o_echo_overflow <= 1'b1;
  end

  // Sequencer next-state and next-output logic; print requests win over pending echoes.
  always_comb begin
    state_d    = state;
    idx_d      = o_msg_idx;
    tx_data_d  = o_tx_data;
    tx_valid_d = o_tx_valid;
    pend_clr   = 1'b0;
    fifo_pop   = 1'b0;
`ifdef UART_SEQ_CRLF_EN
    crlf_lf_d  = crlf_lf;
`endif
    case (state)
      ST_IDLE: begin
        if (pend) begin
          pend_clr = 1'b1;
          idx_d    = '0;
          state_d  = ST_MSG_LOAD;
        end else if (!fifo_empty) begin
          tx_data_d  = fifo_head;
          tx_valid_d = 1'b1;
          state_d    = ST_ECHO_SEND;
        end
      end
      ST_MSG_LOAD: begin
        tx_data_d  = msg_char;
        tx_valid_d = 1'b1;
        state_d    = ST_MSG_SEND;
      end
      ST_MSG_SEND: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          if (o_msg_idx == LAST_IDX) begin
            idx_d = '0;
`ifdef UART_SEQ_CRLF_EN
            crlf_lf_d = 1'b0;
            state_d   = ST_CRLF;
`else
            state_d   = ST_IDLE;
`endif
          end else begin
            idx_d   = o_msg_idx + IDX_W'(1);
            state_d = ST_MSG_LOAD;
          end
        end
      end
      ST_ECHO_SEND: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          fifo_pop   = 1'b1;
          state_d    = ST_IDLE;
        end
      end
`ifdef UART_SEQ_CRLF_EN
      ST_CRLF: begin
        if (!o_tx_valid) begin
          tx_data_d  = crlf_lf ? DATA_W'(ASCII_LF) : DATA_W'(ASCII_CR);
          tx_valid_d = 1'b1;
        end else if (xfer) begin
          tx_valid_d = 1'b0;
          if (crlf_lf) state_d = ST_IDLE;
          else         crlf_lf_d = 1'b1;
        end
      end
`endif
      default: begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and registered TX outputs; reset drops o_tx_valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      o_msg_idx  <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
`ifdef UART_SEQ_CRLF_EN
      crlf_lf    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      o_msg_idx  <= idx_d;
      o_tx_data  <= tx_data_d;
      o_tx_valid <= tx_valid_d;
`ifdef UART_SEQ_CRLF_EN
      crlf_lf    <= crlf_lf_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - randomized self-checking bench for uart_tx_sequencer (honours UART_SEQ_CRLF_EN)
`timescale 1ns/1ps
module tb_uart_tx_sequencer;

  localparam int DATA_W     = 8;
  localparam int MSG_LEN    = 16;
  localparam int IDX_W      = 8;
  localparam int ECHO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              printf = 1'b0;
  logic              tx_ready = 1'b0;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic [DATA_W-1:0] msg_char;
  logic [IDX_W-1:0]  o_msg_idx;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_valid;
  logic              o_busy;
  logic              o_echo_overflow;

  logic [7:0] msg_rom [MSG_LEN];
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         ready_rand = 1'b0;

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = '0;

  uart_tx_sequencer #(
    .DATA_W     (DATA_W),
    .MSG_LEN    (MSG_LEN),
    .IDX_W      (IDX_W),
    .ECHO_DEPTH (ECHO_DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .printf          (printf),
    .msg_char        (msg_char),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .o_msg_idx       (o_msg_idx),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .o_busy          (o_busy),
    .o_echo_overflow (o_echo_overflow)
  );

  always #5 clk = ~clk;

  assign msg_char = msg_rom[o_msg_idx[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte-stream monitor: sampled mid-cycle, a transfer is valid&&ready before the next edge.
  always @(negedge clk) begin
    logic [31:0] want;
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", o_tx_valid, 1);
        check("hold_data", o_tx_data, prev_d);
      end
      if (prev_v && prev_r) check("gap_after_xfer", o_tx_valid, 0);
      if (o_tx_valid && tx_ready) begin
        want = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h100;
        check("tx_byte", o_tx_data, want);
      end
      prev_v = o_tx_valid;
      prev_r = tx_ready;
      prev_d = o_tx_data;
    end
  end

  // Random back-pressure when enabled, offset from the main driver's update time.
  initial forever begin
    @(posedge clk);
    #2;
    if (ready_rand) tx_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic new_rom(input bit ascii);
    for (int i = 0; i < MSG_LEN; i++)
      msg_rom[i] = ascii ? 8'(32'h41 + i) : 8'($urandom);
  endtask

  task automatic expect_msg();
    for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(msg_rom[i]);
`ifdef UART_SEQ_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || o_busy) && t < budget) begin
      tick();
      t++;
    end
    check("drain", exp_q.size(), 0);
    check("busy_after", o_busy, 0);
    check("idx_after", o_msg_idx, 0);
  endtask

  task automatic wait_idx(input int target, input int budget);
    int t = 0;
    while (int'(o_msg_idx) < target && t < budget) begin
      tick();
      t++;
    end
    check("reach_idx", int'(o_msg_idx) >= target, 1);
  endtask

  task automatic wait_valid(input int budget);
    int t = 0;
    while (!o_tx_valid && t < budget) begin
      tick();
      t++;
    end
    check("valid_seen", o_tx_valid, 1);
  endtask

  initial begin
    logic [7:0] b;
    int         k;

    // Reset state
    tick(3);
    check("rst_valid", o_tx_valid, 0);
    check("rst_data", o_tx_data, 0);
    check("rst_idx", o_msg_idx, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovf", o_echo_overflow, 0);
    rst_n = 1'b1;
    tick(2);

    // "A".."P" with 3-cycle request latency
    new_rom(1'b1);
    tx_ready = 1'b1;
    expect_msg();
    printf = ~printf;
    tick(2);
    check("latency_2", o_tx_valid, 0);
    tick();
    check("latency_3", o_tx_valid, 1);
    check("first_char", o_tx_data, 8'h41);
    wait_done(200);

    // Back-pressure mid-message
    new_rom(1'b0);
    expect_msg();
    printf = ~printf;
    wait_idx(5, 100);
    tx_ready = 1'b0;
    tick(10);
    tx_ready = 1'b1;
    wait_done(200);

    // Idle echo, with a print request arriving during the first echo
    tx_ready = 1'b0;
    send_rx(8'h31);
    send_rx(8'h32);
    wait_valid(20);
    check("echo_head", o_tx_data, 8'h31);
    exp_q.push_back(8'h31);
    expect_msg();
    exp_q.push_back(8'h32);
    printf = ~printf;
    tick(4);
    tx_ready = 1'b1;
    wait_done(300);
    check("ovf_clear", o_echo_overflow, 0);

    // Echo FIFO overflow while a message holds the line
    new_rom(1'b0);
    ready_rand = 1'b1;
    expect_msg();
    printf = ~printf;
    wait_idx(2, 200);
    k = $urandom_range(ECHO_DEPTH + 1, ECHO_DEPTH + 3);
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom);
      send_rx(b);
      if (i < ECHO_DEPTH) exp_q.push_back(b);
    end
    wait_done(600);
    check("ovf_set", o_echo_overflow, 1);

    // Random idle echoes followed by random messages
    for (int it = 0; it < 3; it++) begin
      k = $urandom_range(1, ECHO_DEPTH);
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        send_rx(b);
      end
      wait_done(200);
      new_rom(1'b0);
      expect_msg();
      printf = ~printf;
      wait_done(600);
    end
    check("ovf_sticky", o_echo_overflow, 1);

    // Two toggles during a message queue exactly one more
    new_rom(1'b0);
    expect_msg();
    expect_msg();
    printf = ~printf;
    wait_idx(3, 200);
    printf = ~printf;
    tick(2);
    printf = ~printf;
    wait_done(1200);
    tick(20);
    check("no_extra_busy", o_busy, 0);

    // Reset while a byte is waiting for the receiver
    ready_rand = 1'b0;
    tx_ready = 1'b0;
    printf = ~printf;
    wait_valid(20);
    rst_n = 1'b0;
    printf = 1'b0;
    #1;
    check("midrst_valid", o_tx_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_ovf", o_echo_overflow, 0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_idle", o_busy, 0);

    // Normal operation after reset
    new_rom(1'b1);
    tx_ready = 1'b1;
    expect_msg();
    printf = 1'b1;
    wait_done(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
